exp3_placar: RTL and testbench
==============================

EXP3_PLACAR -- requirements
Module: exp3_placar

Interface
REQ-001 The block SHALL have port `clock`, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have port `limpa`, input, 1 bit: synchronous clear of the score.
REQ-004 The block SHALL have port `registra`, input, 1 bit: one-cycle strobe, one compared position (driven from the control unit's register-enable).
REQ-005 The block SHALL have port `igual`, input, 1 bit: compare result (chaves == memoria) for the position being registered.
REQ-006 The block SHALL have port `endereco`, input, 4 bits: current position counter value, sampled with `registra`.
REQ-007 The block SHALL have port `pronto`, input, 1 bit: end-of-sequence indication from the control unit.
REQ-008 The block SHALL have port `acertos`, output, 5 bits: match count, 0..16.
REQ-009 The block SHALL have port `erros`, output, 5 bits: mismatch count, 0..16.
REQ-010 The block SHALL have port `primeiro_erro`, output, 4 bits: `endereco` of the first mismatch in the round.
REQ-011 The block SHALL have port `tem_erro`, output, 1 bit: at least one mismatch registered this round.
REQ-012 The block SHALL have port `resultado_valido`, output, 1 bit: the round is closed and the score is stable.
REQ-013 The block SHALL have port `acertou_tudo`, output, 1 bit: `resultado_valido` and not `tem_erro`.
REQ-014 The block SHALL have port `db_estado_placar`, output, 4 bits: FSM state code for debug.

Function
REQ-015 The FSM SHALL have states OCIOSO=4'h0, ACUMULA=4'h1 and FINAL=4'hF, driven on `db_estado_placar`.
REQ-016 The FSM SHALL leave OCIOSO for ACUMULA on `registra`, counting that sample in the same edge.
REQ-017 In ACUMULA, on `registra`:
- `igual`=1 SHALL increment `acertos`.
- `igual`=0 SHALL increment `erros`.
- If `tem_erro` was 0, `primeiro_erro` SHALL load `endereco` and `tem_erro` SHALL set.
REQ-018 `pronto`=1 in ACUMULA SHALL move the FSM to FINAL; `resultado_valido` SHALL be 1 on the cycle after `pronto` is sampled.
REQ-019 `pronto` and `registra` in the same cycle SHALL count the sample, then enter FINAL with that sample included.
REQ-020 In FINAL all score outputs SHALL hold; a `registra` in FINAL SHALL start a new round: counters clear, the sample is counted, and the FSM goes to ACUMULA in one edge.
REQ-021 `limpa`=1 SHALL take the block to OCIOSO with all outputs at their reset values on the next edge, and SHALL win over a simultaneous `registra` or `pronto` (the sample is dropped).
REQ-022 `acertos` and `erros` SHALL saturate at 16; further strokes SHALL be ignored without wrap-around.
REQ-023 `pronto` in OCIOSO SHALL enter FINAL with a zero score (`acertou_tudo`=1).
REQ-024 All outputs SHALL be registered or decoded only from registered state; there is no combinational path from input to output.

Reset
REQ-025 Asserting `reset`=0 SHALL immediately force:
- state OCIOSO
- `acertos`=0, `erros`=0
- `primeiro_erro`=0
- `tem_erro`=0, `resultado_valido`=0, `acertou_tudo`=0
- `db_estado_placar`=4'h0
REQ-026 Reset mid-round SHALL discard the partial score; the block SHALL resume on the first `clock` edge after `reset` returns to 1.

Configuration
REQ-027 With macro `EXP3_PLACAR_HEX_EN` defined, the block SHALL add outputs `db_acertos_hex[6:0]` and `db_erros_hex[6:0]`, each decoded by `hexa7seg` from the count saturated to 4'hF (16 shows "F").
REQ-028 Without `EXP3_PLACAR_HEX_EN`, those ports and decoders SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-029 The state codes and the count limit (16) SHALL live in a shared include file, `exp3_placar_defs.vh`.
REQ-030 A sub-module, `exp3_contador_sat` (5-bit saturating counter with clear and enable), SHALL be instantiated once for `acertos` and once for `erros`; `hexa7seg` SHALL be reused as-is.

Verification
REQ-031 Scenario: 16 `registra` pulses, all `igual`=1, then `pronto` -> `acertos`=16, `erros`=0, `acertou_tudo`=1, `db_estado_placar`=F.
REQ-032 Scenario: mismatches at `endereco`=5 and `endereco`=9, the rest match, then `pronto` -> `acertos`=14, `erros`=2, `primeiro_erro`=5, `tem_erro`=1, `acertou_tudo`=0.
REQ-033 Scenario: `pronto` and the 16th `registra` (`igual`=0) in the same cycle -> `erros`=1, and `resultado_valido`=1 one cycle later.
REQ-034 Scenario: 20 `registra` pulses with `igual`=1 and no `pronto` -> `acertos` holds at 16.
REQ-035 Scenario: `limpa` and `registra` in the same cycle after 3 counted samples -> all counts 0, state 0; `reset`=0 asynchronously mid-round -> outputs 0 before the next edge.
REQ-036 Scenario: `registra` in FINAL with `igual`=0 at `endereco`=0 -> `erros`=1, `acertos`=0, `primeiro_erro`=0, `db_estado_placar`=1.

Source files
------------

// File: rtl/exp3_placar_pkg.sv
// rtl/exp3_placar_pkg.sv - scoreboard constants and the hex-display saturation helper
package exp3_placar_pkg;

`include "exp3_placar_defs.vh"

   // A full score of 16 does not fit one hex digit, so it is shown as F.
   function automatic logic [3:0] sat_hex(input logic [4:0] valor);
      return (valor > 5'd15) ? 4'hF : valor[3:0];
   endfunction

endpackage

// File: rtl/exp3_contador_sat.sv
// rtl/exp3_contador_sat.sv - 5-bit counter that stops at the score limit, with clear and enable
module exp3_contador_sat
   import exp3_placar_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       limpa,
   input  logic       habilita,
   output logic [4:0] valor
);

   logic [4:0] valor_q, valor_d;

   // Clear together with enable restarts the count at one: the new round's first sample.
   always_comb begin
      valor_d = valor_q;
      if (limpa)
         valor_d = {4'b0000, habilita};
      else if (habilita && (valor_q < PLACAR_LIMITE))
         valor_d = valor_q + 5'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         valor_q <= 5'd0;
      else
         valor_q <= valor_d;
   end

   assign valor = valor_q;

endmodule

// File: rtl/exp3_placar_defs.vh
// rtl/exp3_placar_defs.vh - shared state codes and score limit for the round scoreboard
`ifndef EXP3_PLACAR_DEFS_VH
`define EXP3_PLACAR_DEFS_VH

localparam logic [3:0] OCIOSO  = 4'h0;
localparam logic [3:0] ACUMULA = 4'h1;
localparam logic [3:0] FINAL   = 4'hF;

localparam logic [4:0] PLACAR_LIMITE = 5'd16;

`endif

// File: rtl/hexa7seg.sv
// rtl/hexa7seg.sv - hex digit to active-low seven-segment pattern (gfedcba)
module hexa7seg (
   input  logic [3:0] hexa,
   output logic [6:0] display
);

   always_comb begin
      display = 7'b1111111;
      case (hexa)
         4'h0: display = 7'b1000000;
         4'h1: display = 7'b1111001;
         4'h2: display = 7'b0100100;
         4'h3: display = 7'b0110000;
         4'h4: display = 7'b0011001;
         4'h5: display = 7'b0010010;
         4'h6: display = 7'b0000010;
         4'h7: display = 7'b1111000;
         4'h8: display = 7'b0000000;
         4'h9: display = 7'b0010000;
         4'hA: display = 7'b0001000;
         4'hB: display = 7'b0000011;
         4'hC: display = 7'b1000110;
         4'hD: display = 7'b0100001;
         4'hE: display = 7'b0000110;
         4'hF: display = 7'b0001110;
         default: display = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/exp3_placar.sv
// rtl/exp3_placar.sv - per-round match/mismatch scoreboard; EXP3_PLACAR_HEX_EN adds hex debug displays
module exp3_placar
   import exp3_placar_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       limpa,
   input  logic       registra,
   input  logic       igual,
   input  logic [3:0] endereco,
   input  logic       pronto,
   output logic [4:0] acertos,
   output logic [4:0] erros,
   output logic [3:0] primeiro_erro,
   output logic       tem_erro,
   output logic       resultado_valido,
   output logic       acertou_tudo,
   output logic [3:0] db_estado_placar
`ifdef EXP3_PLACAR_HEX_EN
   ,
   output logic [6:0] db_acertos_hex,
   output logic [6:0] db_erros_hex
`endif
);

   logic [3:0] estado_q, estado_d;
   logic [3:0] primeiro_erro_q, primeiro_erro_d;
   logic       tem_erro_q, tem_erro_d;
   logic       nova_rodada;
   logic       limpa_contagem;
   logic       conta_acerto, conta_erro;

   // A sample arriving after the round closed opens a fresh round.
   assign nova_rodada    = registra && (estado_q == FINAL);
   assign limpa_contagem = limpa || nova_rodada;
   assign conta_acerto   = registra && igual && !limpa;
   assign conta_erro     = registra && !igual && !limpa;

   always_comb begin
      estado_d        = estado_q;
      primeiro_erro_d = primeiro_erro_q;
      tem_erro_d      = tem_erro_q;
      if (limpa) begin
         estado_d        = OCIOSO;
         primeiro_erro_d = 4'h0;
         tem_erro_d      = 1'b0;
      end else begin
         if (nova_rodada) begin
            primeiro_erro_d = 4'h0;
            tem_erro_d      = 1'b0;
         end
         if (registra) begin
            estado_d = ACUMULA;
            if (!igual && !tem_erro_d) begin
               primeiro_erro_d = endereco;
               tem_erro_d      = 1'b1;
            end
         end
         if (pronto)
            estado_d = FINAL;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q        <= OCIOSO;
         primeiro_erro_q <= 4'h0;
         tem_erro_q      <= 1'b0;
      end else begin
         estado_q        <= estado_d;
         primeiro_erro_q <= primeiro_erro_d;
         tem_erro_q      <= tem_erro_d;
      end
   end

   exp3_contador_sat u_acertos (
      .clock    (clock),
      .reset    (reset),
      .limpa    (limpa_contagem),
      .habilita (conta_acerto),
      .valor    (acertos)
   );

   exp3_contador_sat u_erros (
      .clock    (clock),
      .reset    (reset),
      .limpa    (limpa_contagem),
      .habilita (conta_erro),
      .valor    (erros)
   );

   assign primeiro_erro    = primeiro_erro_q;
   assign tem_erro         = tem_erro_q;
   assign resultado_valido = (estado_q == FINAL);
   assign acertou_tudo     = (estado_q == FINAL) && !tem_erro_q;
   assign db_estado_placar = estado_q;

`ifdef EXP3_PLACAR_HEX_EN
   hexa7seg u_hex_acertos (
      .hexa    (sat_hex(acertos)),
      .display (db_acertos_hex)
   );

   hexa7seg u_hex_erros (
      .hexa    (sat_hex(erros)),
      .display (db_erros_hex)
   );
`endif

endmodule

// File: tb/tb_exp3_placar.sv
// tb/tb_exp3_placar.sv - self-checking bench for the round scoreboard
module tb_exp3_placar;

   logic       clock = 1'b0;
   logic       reset;
   logic       limpa, registra, igual, pronto;
   logic [3:0] endereco;
   logic [4:0] acertos, erros;
   logic [3:0] primeiro_erro;
   logic       tem_erro, resultado_valido, acertou_tudo;
   logic [3:0] db_estado_placar;

   int checks   = 0;
   int failures = 0;

   // Reference score: round bookkeeping in plain integers.
   int m_ac, m_er, m_pe;
   bit m_te, m_aberta, m_fechada;

   typedef struct {
      logic       l, r, i;
      logic [3:0] e;
      logic       p;
      int         ac, er, pe;
      logic       te, val, tudo;
      logic [3:0] st;
   } vec_t;

   vec_t tv[12];

   exp3_placar dut (
      .clock            (clock),
      .reset            (reset),
      .limpa            (limpa),
      .registra         (registra),
      .igual            (igual),
      .endereco         (endereco),
      .pronto           (pronto),
      .acertos          (acertos),
      .erros            (erros),
      .primeiro_erro    (primeiro_erro),
      .tem_erro         (tem_erro),
      .resultado_valido (resultado_valido),
      .acertou_tudo     (acertou_tudo),
      .db_estado_placar (db_estado_placar)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nome, input int atual, input int esperado);
      checks++;
      if (atual != esperado) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nome, atual, esperado);
      end
   endtask

   task automatic model_zero();
      m_ac = 0; m_er = 0; m_pe = 0; m_te = 0; m_aberta = 0; m_fechada = 0;
   endtask

   task automatic model_edge();
      if (limpa) begin
         model_zero();
      end else begin
         if (registra) begin
            if (m_fechada) begin
               m_ac = 0; m_er = 0; m_pe = 0; m_te = 0;
            end
            if (igual) m_ac = (m_ac < 16) ? m_ac + 1 : 16;
            else begin
               m_er = (m_er < 16) ? m_er + 1 : 16;
               if (!m_te) begin m_pe = int'(endereco); m_te = 1; end
            end
            m_aberta = 1; m_fechada = 0;
         end
         if (pronto) begin m_fechada = 1; m_aberta = 0; end
      end
   endtask

   task automatic drive(input logic l, input logic r, input logic i, input logic [3:0] e, input logic p);
      limpa = l; registra = r; igual = i; endereco = e; pronto = p;
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_model(input string tag);
      int st;
      st = m_fechada ? 15 : (m_aberta ? 1 : 0);
      chk({tag, ".acertos"}, int'(acertos), m_ac);
      chk({tag, ".erros"}, int'(erros), m_er);
      chk({tag, ".primeiro_erro"}, int'(primeiro_erro), m_pe);
      chk({tag, ".tem_erro"}, int'(tem_erro), int'(m_te));
      chk({tag, ".resultado_valido"}, int'(resultado_valido), int'(m_fechada));
      chk({tag, ".acertou_tudo"}, int'(acertou_tudo), int'(m_fechada && !m_te));
      chk({tag, ".estado"}, int'(db_estado_placar), st);
   endtask

   task automatic rodada(input int n, input int erro_a, input int erro_b);
      for (int k = 0; k < n; k++) begin
         drive(1'b0, 1'b1, !(k == erro_a || k == erro_b), 4'(k), 1'b0);
         cycle();
      end
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
   endtask

   initial begin
      tv[0]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0,  0, 0,  0, 1'b0, 1'b0, 1'b0, 4'h0};
      tv[1]  = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b1,  0, 0,  0, 1'b0, 1'b1, 1'b1, 4'hF};
      tv[2]  = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b0,  0, 1,  0, 1'b1, 1'b0, 1'b0, 4'h1};
      tv[3]  = '{1'b0, 1'b1, 1'b1, 4'd1,  1'b0,  1, 1,  0, 1'b1, 1'b0, 1'b0, 4'h1};
      tv[4]  = '{1'b0, 1'b1, 1'b0, 4'd7,  1'b0,  1, 2,  0, 1'b1, 1'b0, 1'b0, 4'h1};
      tv[5]  = '{1'b0, 1'b0, 1'b0, 4'd9,  1'b0,  1, 2,  0, 1'b1, 1'b0, 1'b0, 4'h1};
      tv[6]  = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b1,  1, 2,  0, 1'b1, 1'b1, 1'b0, 4'hF};
      tv[7]  = '{1'b0, 1'b0, 1'b1, 4'd4,  1'b0,  1, 2,  0, 1'b1, 1'b1, 1'b0, 4'hF};
      tv[8]  = '{1'b0, 1'b1, 1'b1, 4'd3,  1'b0,  1, 0,  0, 1'b0, 1'b0, 1'b0, 4'h1};
      tv[9]  = '{1'b0, 1'b1, 1'b0, 4'd12, 1'b0,  1, 1, 12, 1'b1, 1'b0, 1'b0, 4'h1};
      tv[10] = '{1'b1, 1'b1, 1'b0, 4'd5,  1'b1,  0, 0,  0, 1'b0, 1'b0, 1'b0, 4'h0};
      tv[11] = '{1'b0, 1'b1, 1'b1, 4'd2,  1'b0,  1, 0,  0, 1'b0, 1'b0, 1'b0, 4'h1};

      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      model_zero();
      #12;
      chk_model("reset");
      reset = 1'b1;
      @(posedge clock);
      #1;

      for (int v = 0; v < 12; v++) begin
         drive(tv[v].l, tv[v].r, tv[v].i, tv[v].e, tv[v].p);
         cycle();
         chk($sformatf("vec%0d.acertos", v), int'(acertos), tv[v].ac);
         chk($sformatf("vec%0d.erros", v), int'(erros), tv[v].er);
         chk($sformatf("vec%0d.primeiro_erro", v), int'(primeiro_erro), tv[v].pe);
         chk($sformatf("vec%0d.tem_erro", v), int'(tem_erro), int'(tv[v].te));
         chk($sformatf("vec%0d.valido", v), int'(resultado_valido), int'(tv[v].val));
         chk($sformatf("vec%0d.tudo", v), int'(acertou_tudo), int'(tv[v].tudo));
         chk($sformatf("vec%0d.estado", v), int'(db_estado_placar), int'(tv[v].st));
      end

      // 16 matches then pronto
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0); cycle();
      rodada(16, -1, -1);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1); cycle();
      chk("all16.acertos", int'(acertos), 16);
      chk("all16.erros", int'(erros), 0);
      chk("all16.tudo", int'(acertou_tudo), 1);
      chk("all16.estado", int'(db_estado_placar), 15);

      // mismatches at 5 and 9
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0); cycle();
      rodada(16, 5, 9);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1); cycle();
      chk("two_err.acertos", int'(acertos), 14);
      chk("two_err.erros", int'(erros), 2);
      chk("two_err.primeiro", int'(primeiro_erro), 5);
      chk("two_err.tem_erro", int'(tem_erro), 1);
      chk("two_err.tudo", int'(acertou_tudo), 0);

      // pronto together with the 16th sample (a mismatch)
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0); cycle();
      rodada(15, -1, -1);
      drive(1'b0, 1'b1, 1'b0, 4'hF, 1'b1); cycle();
      chk("same_cyc.acertos", int'(acertos), 15);
      chk("same_cyc.erros", int'(erros), 1);
      chk("same_cyc.primeiro", int'(primeiro_erro), 15);
      chk("same_cyc.valido", int'(resultado_valido), 1);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

      // saturation after 20 matches
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0); cycle();
      rodada(20, -1, -1);
      chk("sat.acertos", int'(acertos), 16);
      chk("sat.estado", int'(db_estado_placar), 1);
      chk("sat.valido", int'(resultado_valido), 0);

      // limpa beats registra after 3 samples
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0); cycle();
      rodada(3, 1, -1);
      drive(1'b1, 1'b1, 1'b0, 4'h6, 1'b0); cycle();
      chk("limpa_wins.acertos", int'(acertos), 0);
      chk("limpa_wins.erros", int'(erros), 0);
      chk("limpa_wins.tem_erro", int'(tem_erro), 0);
      chk("limpa_wins.estado", int'(db_estado_placar), 0);

      // asynchronous reset mid-round, observed between edges
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      rodada(3, 0, -1);
      reset = 1'b0;
      model_zero();
      #2;
      chk_model("async_rst");
      #2;
      reset = 1'b1;
      @(posedge clock);
      #1;
      drive(1'b0, 1'b1, 1'b1, 4'h0, 1'b0); cycle();
      chk_model("resume");

      // randomized traffic against the reference score
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0); cycle();
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
               $urandom_range(0, 19) == 0);
         if (m_fechada && registra) pronto = 1'b0;
         cycle();
         chk_model($sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
